// File: rtl/cc_bus_pkg.sv
// rtl/cc_bus_pkg.sv - address map constants and watchdog state encoding for bus_responder
// Contents: CPU address-range bounds, watchdog FSM state type, range helper.
package cc_bus_pkg;

    localparam logic [15:0] RAM_HI    = 16'h8FFF;
    localparam logic [15:0] IO_LO     = 16'h9000;
    localparam logic [15:0] IO_HI     = 16'h9FFF;
    localparam logic [15:0] INTACK_LO = 16'h9E00;
    localparam logic [15:0] INTACK_HI = 16'h9E7F;
    localparam logic [15:0] WDOG_LO   = 16'h9E80;
    localparam logic [15:0] WDOG_HI   = 16'h9EFF;
    localparam logic [15:0] ROM_LO    = 16'hA000;

    typedef enum logic {
        WD_RUN  = 1'b0,
        WD_FIRE = 1'b1
    } wd_state_t;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser
// Ports: clk, rst_n (async active-low), d (asynchronous input), q (synchronised output).
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU address decode, interrupt acknowledge strobe, IRQ clock and VBLANK watchdog
// Ports: clk, RESETn (async active-low); BA/BRWn/WRITEn CPU bus; VBLANK, V32 video timing;
//        RAMSELn/IOSELn/ROMSELn selects; INTACKn ack pulse; IRQCK interrupt clock; WDRESETn watchdog reset.
module bus_responder #(
    parameter int WDOG_LIMIT = 8,
    parameter int WDRST_LEN  = 16
) (
    input  logic        clk,
    input  logic        RESETn,
    input  logic [15:0] BA,
    input  logic        BRWn,
    input  logic        WRITEn,
    input  logic        VBLANK,
    input  logic        V32,
    output logic        RAMSELn,
    output logic        IOSELn,
    output logic        ROMSELn,
    output logic        INTACKn,
    output logic        IRQCK,
    output logic        WDRESETn
);

    import cc_bus_pkg::*;

    localparam logic [3:0] LIMIT      = 4'(WDOG_LIMIT);
    localparam logic [4:0] TIMER_LAST = 5'(WDRST_LEN - 1);

    logic      is_intack;
    logic      is_wdog;
    logic      write_q;
    logic      write_evt;
    logic      vb_sync;
    logic      vb_prev;
    logic      vb_rise;
    logic      wdog_evt;
    wd_state_t state;
    logic [3:0] wd_count;
    logic [4:0] wd_timer;

    // The two strobe windows sit inside the I/O page and steal it from IOSELn.
    always_comb begin
        is_intack = in_range(BA, INTACK_LO, INTACK_HI);
        is_wdog   = in_range(BA, WDOG_LO, WDOG_HI);
        RAMSELn   = !(BA <= RAM_HI);
        IOSELn    = !(in_range(BA, IO_LO, IO_HI) && !is_intack && !is_wdog);
        ROMSELn   = !(BA >= ROM_LO);
    end

    // Falling edge of the write strobe; held-low strobes yield a single event.
    assign write_evt = write_q && !WRITEn && !BRWn;
    assign wdog_evt  = write_evt && is_wdog;
    assign vb_rise   = vb_sync && !vb_prev;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            write_q <= 1'b1;
            INTACKn <= 1'b1;
            vb_prev <= 1'b0;
        end else begin
            write_q <= WRITEn;
            INTACKn <= !(write_evt && is_intack);
            vb_prev <= vb_sync;
        end
    end

    sync2 u_sync_v32 (
        .clk   (clk),
        .rst_n (RESETn),
        .d     (V32),
        .q     (IRQCK)
    );

    sync2 u_sync_vblank (
        .clk   (clk),
        .rst_n (RESETn),
        .d     (VBLANK),
        .q     (vb_sync)
    );

    // Watchdog: a kick clears the count; reaching the limit fires a fixed-width reset pulse.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state    <= WD_RUN;
            wd_count <= 4'd0;
            wd_timer <= 5'd0;
            WDRESETn <= 1'b1;
        end else begin
            case (state)
                WD_RUN: begin
                    if (wdog_evt) begin
                        wd_count <= 4'd0;
                    end else if (vb_rise && (wd_count < LIMIT)) begin
                        wd_count <= wd_count + 4'd1;
                        if (wd_count + 4'd1 == LIMIT) begin
                            state    <= WD_FIRE;
                            wd_timer <= 5'd0;
                            WDRESETn <= 1'b0;
                        end
                    end
                end
                WD_FIRE: begin
                    if (wd_timer == TIMER_LAST) begin
                        state    <= WD_RUN;
                        wd_count <= 4'd0;
                        wd_timer <= 5'd0;
                        WDRESETn <= 1'b1;
                    end else begin
                        wd_timer <= wd_timer + 5'd1;
                    end
                end
                default: state <= WD_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - scoreboard bench for bus_responder
module tb_bus_responder;

    localparam int LIMIT = 8;
    localparam int PULSE = 16;

    logic        clk = 1'b0;
    logic        RESETn = 1'b1;
    logic [15:0] BA = 16'h0000;
    logic        BRWn = 1'b1;
    logic        WRITEn = 1'b1;
    logic        VBLANK = 1'b0;
    logic        V32 = 1'b0;
    logic        RAMSELn, IOSELn, ROMSELn, INTACKn, IRQCK, WDRESETn;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_responder #(.WDOG_LIMIT(LIMIT), .WDRST_LEN(PULSE)) dut (
        .clk      (clk),
        .RESETn   (RESETn),
        .BA       (BA),
        .BRWn     (BRWn),
        .WRITEn   (WRITEn),
        .VBLANK   (VBLANK),
        .V32      (V32),
        .RAMSELn  (RAMSELn),
        .IOSELn   (IOSELn),
        .ROMSELn  (ROMSELn),
        .INTACKn  (INTACKn),
        .IRQCK    (IRQCK),
        .WDRESETn (WDRESETn)
    );

    typedef struct packed {
        logic ram;
        logic io;
        logic rom;
        logic intack;
        logic irq;
        logic wdrst;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: sample histories plus integer counters.
    logic v32_hist[$];
    logic vb_hist[$];
    logic m_prev_wr;
    int   m_edges;
    int   m_fire_left;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        v32_hist.delete();
        vb_hist.delete();
        for (int i = 0; i < 4; i++) begin
            v32_hist.push_front(1'b0);
            vb_hist.push_front(1'b0);
        end
        m_prev_wr   = 1'b1;
        m_edges     = 0;
        m_fire_left = 0;
    endtask

    // Called just after a rising edge, with the inputs that edge sampled still applied.
    task automatic model_edge();
        logic ev, rise, ack;
        exp_t e;
        v32_hist.push_front(V32);
        vb_hist.push_front(VBLANK);
        while (v32_hist.size() > 4) void'(v32_hist.pop_back());
        while (vb_hist.size() > 4) void'(vb_hist.pop_back());
        ev = m_prev_wr && !WRITEn && !BRWn;
        m_prev_wr = WRITEn;
        rise = vb_hist[2] && !vb_hist[3];
        ack = ev && (BA >= 16'h9E00) && (BA < 16'h9E80);
        if (m_fire_left > 0) begin
            m_fire_left--;
            if (m_fire_left == 0) m_edges = 0;
        end else if (ev && (BA >= 16'h9E80) && (BA < 16'h9F00)) begin
            m_edges = 0;
        end else if (rise) begin
            m_edges++;
            if (m_edges == LIMIT) m_fire_left = PULSE;
        end
        e.ram    = !(BA < 16'h9000);
        e.io     = !((BA >= 16'h9000) && (BA < 16'hA000) && !((BA >= 16'h9E00) && (BA < 16'h9F00)));
        e.rom    = !(BA >= 16'hA000);
        e.intack = !ack;
        e.irq    = v32_hist[1];
        e.wdrst  = (m_fire_left == 0);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("RAMSELn", {15'd0, RAMSELn}, {15'd0, e.ram});
            chk("IOSELn", {15'd0, IOSELn}, {15'd0, e.io});
            chk("ROMSELn", {15'd0, ROMSELn}, {15'd0, e.rom});
            chk("INTACKn", {15'd0, INTACKn}, {15'd0, e.intack});
            chk("IRQCK", {15'd0, IRQCK}, {15'd0, e.irq});
            chk("WDRESETn", {15'd0, WDRESETn}, {15'd0, e.wdrst});
        end
    end

    task automatic step(input logic [15:0] ba, input logic brwn, input logic writen,
                        input logic vb, input logic v32);
        BA = ba; BRWn = brwn; WRITEn = writen; VBLANK = vb; V32 = v32;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h0100, 1'b1, 1'b1, VBLANK, V32);
    endtask

    task automatic vb_edge();
        step(16'h0100, 1'b1, 1'b1, 1'b1, V32);
        step(16'h0100, 1'b1, 1'b1, 1'b1, V32);
        step(16'h0100, 1'b1, 1'b1, 1'b0, V32);
        step(16'h0100, 1'b1, 1'b1, 1'b0, V32);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_INTACKn"}, {15'd0, INTACKn}, 16'd1);
        chk({tag, "_IRQCK"}, {15'd0, IRQCK}, 16'd0);
        chk({tag, "_WDRESETn"}, {15'd0, WDRESETn}, 16'd1);
        chk({tag, "_count"}, {12'd0, dut.wd_count}, 16'd0);
    endtask

    logic [15:0] sweep [7] = '{16'h0000, 16'h8FFF, 16'h9000, 16'h9E00, 16'h9E80, 16'hA000, 16'hFFFF};

    initial begin : stim
        logic [15:0] ba;
        logic vb, v32, wr, rw;
        int sel;

        // Power-on reset.
        model_reset();
        #1 RESETn = 1'b0;
        #1 check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 RESETn = 1'b1;

        // Address map sweep.
        foreach (sweep[i]) step(sweep[i], 1'b1, 1'b1, 1'b0, 1'b0);

        // Write held low for three cycles at the INTACK window.
        step(16'h9E10, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(16'h9E10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(16'h9E10, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // V32 toggle and a read of the INTACK window.
        for (int i = 0; i < 4; i++) step(16'h0200, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(16'h0200, 1'b1, 1'b1, 1'b0, 1'b0);
        step(16'h9E00, 1'b1, 1'b1, 1'b0, 1'b0);
        step(16'h9E00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(16'h9E00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(16'h9E00, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Eight unkicked VBLANK edges fire the watchdog.
        for (int i = 0; i < LIMIT; i++) vb_edge();
        idle(20);
        chk("count_after_fire", {12'd0, dut.wd_count}, 16'(m_edges));

        // Seven edges, then a kick landing on the same edge as the eighth.
        for (int i = 0; i < LIMIT - 1; i++) vb_edge();
        step(16'h0100, 1'b1, 1'b1, 1'b1, 1'b0);
        step(16'h9E90, 1'b0, 1'b1, 1'b1, 1'b0);
        step(16'h9E90, 1'b0, 1'b0, 1'b0, 1'b0);
        step(16'h0100, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("count_after_kick", {12'd0, dut.wd_count}, 16'(m_edges));

        // Fire again and abort with reset in the fifth cycle of the pulse.
        for (int i = 0; i < LIMIT; i++) vb_edge();
        for (int i = 0; i < 40 && m_fire_left != PULSE - 4; i++) idle(1);
        chk("wdreset_low_before_abort", {15'd0, WDRESETn}, 16'd0);
        RESETn = 1'b0;
        #1 check_reset_outputs("abort");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 RESETn = 1'b1;
        for (int i = 0; i < LIMIT - 1; i++) vb_edge();
        idle(6);
        for (int i = 0; i < 1; i++) vb_edge();
        idle(20);

        // Randomised traffic.
        vb = 1'b0;
        v32 = 1'b0;
        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       ba = 16'h9E00 | 16'($urandom_range(0, 16'h7F));
                1:       ba = 16'h9E80 | 16'($urandom_range(0, 16'h7F));
                2:       ba = 16'h9000 | 16'($urandom_range(0, 16'hFFF));
                default: ba = 16'($urandom_range(0, 16'hFFFF));
            endcase
            wr  = ($urandom_range(0, 2) != 0);
            rw  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) vb = ~vb;
            if ($urandom_range(0, 2) == 0) v32 = ~v32;
            step(ba, rw, wr, vb, v32);
        end
        idle(4);
        chk("count_final", {12'd0, dut.wd_count}, 16'(m_edges));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
